// File: rtl/axi_wide_mem_adapter.sv
// 64-bit to 128-bit AXI4 data-width adapter with per-beat lane tracking from burst address/size/type.
// Optional AXI_UPSIZE_REPLICATE_EN: read data is shifted to byte 0 and replicated by transfer size.
module axi_wide_mem_adapter #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 28,
    parameter int CMD_DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // narrow-side write address
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    // narrow-side write data
    input  logic [63:0]               s_axi_wdata,
    input  logic [7:0]                s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    // narrow-side write response
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    // narrow-side read address
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    // narrow-side read data
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [63:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    // wide-side write address
    output logic [AXI_ID_WIDTH-1:0]   m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awlock,
    output logic [3:0]                m_axi_awcache,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    // wide-side write data
    output logic [127:0]              m_axi_wdata,
    output logic [15:0]               m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    // wide-side write response
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    // wide-side read address
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    // wide-side read data
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [127:0]              m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    // tracker state (0 = IDLE, 1 = ACTIVE)
    output logic                      dbg_wr_state,
    output logic                      dbg_rd_state
);

    localparam int PW = $clog2(CMD_DEPTH);

    typedef struct packed {
        logic [3:0] off;
        logic [2:0] size;
        logic [7:0] len;
        logic [1:0] burst;
    } cmd_t;

    typedef enum logic {
        TRK_IDLE   = 1'b0,
        TRK_ACTIVE = 1'b1
    } trk_state_e;

    function automatic logic [1:0] eff_size(input logic [2:0] s);
        return (s > 3'd3) ? 2'd3 : s[1:0];
    endfunction

    function automatic logic [3:0] next_off(input cmd_t c, input logic [3:0] off);
        logic [1:0] sz;
        logic [3:0] step;
        logic [3:0] mask;
        sz   = eff_size(c.size);
        step = 4'd1 << sz;
        mask = 4'(((({4'd0, c.len}) + 12'd1) << sz) - 12'd1);
        case (c.burst)
            2'b00:   next_off = off;
            2'b10:   next_off = (off & ~mask) | ((off + step) & mask);
            default: next_off = off + step;
        endcase
    endfunction

    // ---------------- write address channel and command FIFO ----------------
    cmd_t          wq_mem_q [CMD_DEPTH];
    logic [PW:0]   wq_wr_q, wq_rd_q, wq_used;
    logic          wq_empty, wq_full;
    logic          aw_hs, w_hs, w_pop;
    cmd_t          w_head;

    assign wq_used  = wq_wr_q - wq_rd_q;
    assign wq_empty = (wq_used == '0);
    assign wq_full  = (wq_used == (PW+1)'(CMD_DEPTH));

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    // Full uses the registered count, so a slot freed by this cycle's pop is only offered next cycle.
    assign m_axi_awvalid = s_axi_awvalid & ~wq_full & ~rst;
    assign s_axi_awready = m_axi_awready & ~wq_full & ~rst;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wq_wr_q <= '0;
            wq_rd_q <= '0;
        end else begin
            if (aw_hs) wq_wr_q <= wq_wr_q + 1'b1;
            if (w_pop) wq_rd_q <= wq_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) wq_mem_q[wq_wr_q[PW-1:0]] <= {s_axi_awaddr[3:0], s_axi_awsize, s_axi_awlen, s_axi_awburst};
    end

    // ---------------- write data tracker ----------------
    trk_state_e    w_state_q;
    logic [7:0]    w_cnt_q;
    logic [3:0]    w_off_q, w_off;

    assign w_head = wq_mem_q[wq_rd_q[PW-1:0]];
    // First beat of a burst takes its lane straight from the FIFO head, so no load cycle is needed.
    assign w_off  = (w_cnt_q == 8'd0) ? w_head.off : w_off_q;

    assign s_axi_wready = m_axi_wready & ~wq_empty;
    assign m_axi_wvalid = s_axi_wvalid & ~wq_empty;
    assign m_axi_wdata  = {s_axi_wdata, s_axi_wdata};
    assign m_axi_wstrb  = w_off[3] ? {s_axi_wstrb, 8'h00} : {8'h00, s_axi_wstrb};
    assign m_axi_wlast  = s_axi_wlast;
    assign w_hs         = s_axi_wvalid & s_axi_wready;
    assign w_pop        = w_hs & s_axi_wlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= TRK_IDLE;
            w_cnt_q   <= '0;
            w_off_q   <= '0;
        end else begin
            case (w_state_q)
                TRK_IDLE:   if (aw_hs) w_state_q <= TRK_ACTIVE;
                TRK_ACTIVE: if (w_pop && !aw_hs && wq_used == (PW+1)'(1)) w_state_q <= TRK_IDLE;
                default:    w_state_q <= TRK_IDLE;
            endcase
            if (w_hs) begin
                if (s_axi_wlast) begin
                    w_cnt_q <= '0;
                end else begin
                    w_cnt_q <= w_cnt_q + 8'd1;
                    w_off_q <= next_off(w_head, w_off);
                end
            end
        end
    end

    assign dbg_wr_state = w_state_q;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;

    // ---------------- read address channel and command FIFO ----------------
    cmd_t          rq_mem_q [CMD_DEPTH];
    logic [PW:0]   rq_wr_q, rq_rd_q, rq_used;
    logic          rq_empty, rq_full;
    logic          ar_hs, r_hs, r_pop;
    cmd_t          r_head;

    assign rq_used  = rq_wr_q - rq_rd_q;
    assign rq_empty = (rq_used == '0);
    assign rq_full  = (rq_used == (PW+1)'(CMD_DEPTH));

    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arvalid = s_axi_arvalid & ~rq_full & ~rst;
    assign s_axi_arready = m_axi_arready & ~rq_full & ~rst;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_wr_q <= '0;
            rq_rd_q <= '0;
        end else begin
            if (ar_hs) rq_wr_q <= rq_wr_q + 1'b1;
            if (r_pop) rq_rd_q <= rq_rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) rq_mem_q[rq_wr_q[PW-1:0]] <= {s_axi_araddr[3:0], s_axi_arsize, s_axi_arlen, s_axi_arburst};
    end

    // ---------------- read data tracker ----------------
    trk_state_e    r_state_q;
    logic [7:0]    r_cnt_q;
    logic [3:0]    r_off_q, r_off;
    logic [63:0]   r_half;

    assign r_head = rq_mem_q[rq_rd_q[PW-1:0]];
    assign r_off  = (r_cnt_q == 8'd0) ? r_head.off : r_off_q;

    assign m_axi_rready = s_axi_rready & ~rq_empty;
    assign s_axi_rvalid = m_axi_rvalid & ~rq_empty;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rlast  = m_axi_rlast;
    assign r_hs         = m_axi_rvalid & m_axi_rready;
    assign r_pop        = r_hs & m_axi_rlast;
    assign r_half       = r_off[3] ? m_axi_rdata[127:64] : m_axi_rdata[63:0];

`ifdef AXI_UPSIZE_REPLICATE_EN
    logic [63:0] r_shift;
    assign r_shift = r_half >> {r_off[2:0], 3'b000};

    always_comb begin
        s_axi_rdata = r_shift;
        case (eff_size(r_head.size))
            2'd0:    s_axi_rdata = {8{r_shift[7:0]}};
            2'd1:    s_axi_rdata = {4{r_shift[15:0]}};
            2'd2:    s_axi_rdata = {2{r_shift[31:0]}};
            default: s_axi_rdata = r_shift;
        endcase
    end
`else
    assign s_axi_rdata = r_half;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= TRK_IDLE;
            r_cnt_q   <= '0;
            r_off_q   <= '0;
        end else begin
            case (r_state_q)
                TRK_IDLE:   if (ar_hs) r_state_q <= TRK_ACTIVE;
                TRK_ACTIVE: if (r_pop && !ar_hs && rq_used == (PW+1)'(1)) r_state_q <= TRK_IDLE;
                default:    r_state_q <= TRK_IDLE;
            endcase
            if (r_hs) begin
                if (m_axi_rlast) begin
                    r_cnt_q <= '0;
                end else begin
                    r_cnt_q <= r_cnt_q + 8'd1;
                    r_off_q <= next_off(r_head, r_off);
                end
            end
        end
    end

    assign dbg_rd_state = r_state_q;

`ifndef SYNTHESIS
    // Hardware follows the last flags; a disagreement with the burst length is only reported.
    wlast_matches_len: assert property (@(posedge clk) disable iff (rst)
        w_hs |-> (s_axi_wlast == (w_cnt_q == w_head.len)));
    rlast_matches_len: assert property (@(posedge clk) disable iff (rst)
        r_hs |-> (m_axi_rlast == (r_cnt_q == r_head.len)));
`endif

endmodule

// File: tb/tb_axi_wide_mem_adapter.sv
// Directed bench for axi_wide_mem_adapter: lane placement, FIFO backpressure, W-before-AW, reset mid-burst.
module tb_axi_wide_mem_adapter;
    localparam int IDW = 4;
    localparam int AW  = 28;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [AW-1:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]     s_axi_awlen, s_axi_arlen;
    logic [2:0]     s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
    logic [1:0]     s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic           s_axi_awlock, s_axi_arlock;
    logic [3:0]     s_axi_awcache, s_axi_arcache;
    logic           s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
    logic [63:0]    s_axi_wdata, s_axi_rdata;
    logic [7:0]     s_axi_wstrb;
    logic           s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic           s_axi_bvalid, s_axi_bready;
    logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [IDW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0]  m_axi_awaddr, m_axi_araddr;
    logic [7:0]     m_axi_awlen, m_axi_arlen;
    logic [2:0]     m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]     m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic           m_axi_awlock, m_axi_arlock;
    logic [3:0]     m_axi_awcache, m_axi_arcache;
    logic           m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [127:0]   m_axi_wdata, m_axi_rdata;
    logic [15:0]    m_axi_wstrb;
    logic           m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic           m_axi_bvalid, m_axi_bready;
    logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic           dbg_wr_state, dbg_rd_state;

    axi_wide_mem_adapter #(.AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic [AW-1:0] a, input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bt);
        s_axi_awaddr = a; s_axi_awsize = sz; s_axi_awlen = ln; s_axi_awburst = bt;
    endtask

    task automatic set_ar(input logic [AW-1:0] a, input logic [2:0] sz, input logic [7:0] ln, input logic [1:0] bt);
        s_axi_araddr = a; s_axi_arsize = sz; s_axi_arlen = ln; s_axi_arburst = bt;
    endtask

    task automatic send_ar(input string tag);
        s_axi_arvalid = 1'b1;
        #1;
        chk(tag, 128'(s_axi_arready), 128'(1));
        step();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic [127:0] d, input logic last, input logic [63:0] exp);
        m_axi_rdata = d; m_axi_rlast = last; m_axi_rvalid = 1'b1;
        #1;
        chk({tag, "_valid"}, 128'(s_axi_rvalid), 128'(1));
        chk({tag, "_data"}, 128'(s_axi_rdata), 128'(exp));
        step();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    endtask

    logic [127:0] rd_d [4];
    logic [63:0]  rd_e [4];
    logic [AW-1:0] bp_a [5];

    initial begin
        rst = 1'b1;
        s_axi_awid = 4'h3; s_axi_awlock = 1'b0; s_axi_awcache = 4'h0; s_axi_awprot = 3'h0;
        s_axi_arid = 4'h5; s_axi_arlock = 1'b0; s_axi_arcache = 4'h0; s_axi_arprot = 3'h0;
        set_aw('0, 3'd3, 8'd0, 2'b01); set_ar('0, 3'd3, 8'd0, 2'b01);
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        m_axi_awready = 1'b1; m_axi_arready = 1'b1; m_axi_wready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b1;

        // reset state
        #3;
        chk("rst_awready", 128'(s_axi_awready), 128'(0));
        chk("rst_arready", 128'(s_axi_arready), 128'(0));
        chk("rst_wready", 128'(s_axi_wready), 128'(0));
        chk("rst_rvalid", 128'(s_axi_rvalid), 128'(0));
        m_axi_rvalid = 1'b0;
        step(); step();
        rst = 1'b0;
        m_axi_rvalid = 1'b1;
        #1;
        chk("idle_awready", 128'(s_axi_awready), 128'(1));
        chk("idle_arready", 128'(s_axi_arready), 128'(1));
        chk("empty_rvalid", 128'(s_axi_rvalid), 128'(0));
        chk("empty_rready", 128'(m_axi_rready), 128'(0));
        m_axi_rvalid = 1'b0;

        // single write to upper lane
        set_aw(28'h0000008, 3'd3, 8'd0, 2'b01);
        s_axi_awvalid = 1'b1;
        #1;
        chk("sw_awvalid", 128'(m_axi_awvalid), 128'(1));
        chk("sw_awaddr", 128'(m_axi_awaddr), 128'h8);
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 64'h1122334455667788; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        #1;
        chk("sw_wready", 128'(s_axi_wready), 128'(1));
        chk("sw_wstrb", 128'(m_axi_wstrb), 128'hFF00);
        chk("sw_wdata_hi", 128'(m_axi_wdata[127:64]), 128'h1122334455667788);
        chk("sw_wlast", 128'(m_axi_wlast), 128'(1));
        step();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 4'h3; m_axi_bresp = 2'b00;
        #1;
        chk("sw_bvalid", 128'(s_axi_bvalid), 128'(1));
        chk("sw_bid", 128'(s_axi_bid), 128'h3);
        chk("sw_bready", 128'(m_axi_bready), 128'(1));
        step();
        m_axi_bvalid = 1'b0;
        #1;
        chk("sw_wr_idle", 128'(dbg_wr_state), 128'(0));

        // INCR read, size 3, len 3: lanes lower, upper, lower, upper
        rd_d[0] = {64'hA1A1_0000_0000_0000, 64'hB0B0_0000_0000_0000};
        rd_d[1] = {64'hA1A1_0000_0000_0001, 64'hB0B0_0000_0000_0001};
        rd_d[2] = {64'hA1A1_0000_0000_0002, 64'hB0B0_0000_0000_0002};
        rd_d[3] = {64'hA1A1_0000_0000_0003, 64'hB0B0_0000_0000_0003};
        rd_e[0] = 64'hB0B0_0000_0000_0000; rd_e[1] = 64'hA1A1_0000_0000_0001;
        rd_e[2] = 64'hB0B0_0000_0000_0002; rd_e[3] = 64'hA1A1_0000_0000_0003;
        set_ar(28'h0000000, 3'd3, 8'd3, 2'b01);
        send_ar("incr_ar");
        for (int i = 0; i < 4; i++) rd_beat($sformatf("incr_r%0d", i), rd_d[i], (i == 3), rd_e[i]);
        #1;
        chk("incr_rd_idle", 128'(dbg_rd_state), 128'(0));

        // WRAP read at 0x18: upper, lower, upper, lower
        rd_e[0] = 64'hA1A1_0000_0000_0000; rd_e[1] = 64'hB0B0_0000_0000_0001;
        rd_e[2] = 64'hA1A1_0000_0000_0002; rd_e[3] = 64'hB0B0_0000_0000_0003;
        set_ar(28'h0000018, 3'd3, 8'd3, 2'b10);
        send_ar("wrap_ar");
        for (int i = 0; i < 4; i++) rd_beat($sformatf("wrap_r%0d", i), rd_d[i], (i == 3), rd_e[i]);
        m_axi_rvalid = 1'b1;
        #1;
        chk("wrap_popped_once", 128'(s_axi_rvalid), 128'(0));
        m_axi_rvalid = 1'b0;

        // size-2 INCR read at 0x4: offsets 4, 8, 12 -> lower, upper, upper
        rd_d[0] = {64'hE0E0_0001_E0E0_0001, 64'hC0C0_0001_C0C0_0001};
        rd_d[1] = {64'hE0E0_0002_E0E0_0002, 64'hC0C0_0002_C0C0_0002};
        rd_d[2] = {64'hE0E0_0003_E0E0_0003, 64'hC0C0_0003_C0C0_0003};
        set_ar(28'h0000004, 3'd2, 8'd2, 2'b01);
        send_ar("s2_ar");
        rd_beat("s2_r0", rd_d[0], 1'b0, 64'hC0C0_0001_C0C0_0001);
        rd_beat("s2_r1", rd_d[1], 1'b0, 64'hE0E0_0002_E0E0_0002);
        rd_beat("s2_r2", rd_d[2], 1'b1, 64'hE0E0_0003_E0E0_0003);

        // backpressure: four ARs fill the FIFO, the fifth waits for the first rlast
        bp_a[0] = 28'h0; bp_a[1] = 28'h8; bp_a[2] = 28'h0; bp_a[3] = 28'h8; bp_a[4] = 28'h8;
        for (int i = 0; i < 4; i++) begin
            set_ar(bp_a[i], 3'd3, 8'd0, 2'b01);
            s_axi_arvalid = 1'b1;
            #1;
            chk($sformatf("bp_accept%0d", i), 128'(s_axi_arready), 128'(1));
            step();
        end
        set_ar(bp_a[4], 3'd3, 8'd0, 2'b01);
        #1;
        chk("bp_full_arready", 128'(s_axi_arready), 128'(0));
        chk("bp_full_arvalid", 128'(m_axi_arvalid), 128'(0));
        step();
        chk("bp_full_hold", 128'(s_axi_arready), 128'(0));
        m_axi_rdata = {64'h5500_0000_0000_0010, 64'hAA00_0000_0000_0010}; m_axi_rlast = 1'b1; m_axi_rvalid = 1'b1;
        #1;
        chk("bp_pop_cycle_arready", 128'(s_axi_arready), 128'(0));
        chk("bp_first_data", 128'(s_axi_rdata), 128'hAA00_0000_0000_0010);
        step();
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        #1;
        chk("bp_after_pop_arready", 128'(s_axi_arready), 128'(1));
        step();
        s_axi_arvalid = 1'b0;
        rd_beat("bp_r1", {64'h5500_0000_0000_0011, 64'hAA00_0000_0000_0011}, 1'b1, 64'h5500_0000_0000_0011);
        rd_beat("bp_r2", {64'h5500_0000_0000_0012, 64'hAA00_0000_0000_0012}, 1'b1, 64'hAA00_0000_0000_0012);
        rd_beat("bp_r3", {64'h5500_0000_0000_0013, 64'hAA00_0000_0000_0013}, 1'b1, 64'h5500_0000_0000_0013);
        rd_beat("bp_r4", {64'h5500_0000_0000_0014, 64'hAA00_0000_0000_0014}, 1'b1, 64'h5500_0000_0000_0014);

        // W presented before AW
        s_axi_wdata = 64'hDEADBEEF0BADF00D; s_axi_wstrb = 8'h0F; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("wfirst_wready%0d", i), 128'(s_axi_wready), 128'(0));
            chk($sformatf("wfirst_wvalid%0d", i), 128'(m_axi_wvalid), 128'(0));
            step();
        end
        set_aw(28'h0000028, 3'd2, 8'd0, 2'b01);
        s_axi_awvalid = 1'b1;
        #1;
        chk("wfirst_aw_cycle_wready", 128'(s_axi_wready), 128'(0));
        step();
        s_axi_awvalid = 1'b0;
        #1;
        chk("wfirst_wready_go", 128'(s_axi_wready), 128'(1));
        chk("wfirst_wstrb", 128'(m_axi_wstrb), 128'h0F00);
        chk("wfirst_wdata", m_axi_wdata, {64'hDEADBEEF0BADF00D, 64'hDEADBEEF0BADF00D});
        step();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;

        // reset during beat 2 of a len-7 write
        set_aw(28'h0000000, 3'd3, 8'd7, 2'b01);
        s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        #1;
        chk("rmb_beat0_strb", 128'(m_axi_wstrb), 128'h00FF);
        step();
        #1;
        chk("rmb_beat1_strb", 128'(m_axi_wstrb), 128'hFF00);
        step();
        rst = 1'b1;
        s_axi_awvalid = 1'b1;
        #1;
        chk("rmb_wready", 128'(s_axi_wready), 128'(0));
        chk("rmb_wvalid", 128'(m_axi_wvalid), 128'(0));
        chk("rmb_awready", 128'(s_axi_awready), 128'(0));
        chk("rmb_awvalid", 128'(m_axi_awvalid), 128'(0));
        chk("rmb_arready", 128'(s_axi_arready), 128'(0));
        chk("rmb_wr_state", 128'(dbg_wr_state), 128'(0));
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        step();
        rst = 1'b0;
        s_axi_wvalid = 1'b1;
        #1;
        chk("rmb_fifo_empty", 128'(s_axi_wready), 128'(0));
        s_axi_wvalid = 1'b0;
        set_aw(28'h0000008, 3'd3, 8'd1, 2'b01);
        s_axi_awvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wdata = 64'h0123456789ABCDEF; s_axi_wvalid = 1'b1;
        #1;
        chk("fresh_beat0_strb", 128'(m_axi_wstrb), 128'hFF00);
        step();
        s_axi_wlast = 1'b1;
        #1;
        chk("fresh_beat1_strb", 128'(m_axi_wstrb), 128'h00FF);
        step();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        #1;
        chk("fresh_wr_idle", 128'(dbg_wr_state), 128'(0));

        // size-0 read at 0x5 with byte 0xAB on lane 5
        set_ar(28'h0000005, 3'd0, 8'd0, 2'b01);
        send_ar("byte_ar");
`ifdef AXI_UPSIZE_REPLICATE_EN
        rd_beat("byte_r", {64'h123456789ABCDEF0, 64'h0000AB0000000000}, 1'b1, 64'hABABABABABABABAB);
`else
        rd_beat("byte_r", {64'h123456789ABCDEF0, 64'h0000AB0000000000}, 1'b1, 64'h0000AB0000000000);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
